lsu_mem_stage: RTL

Memory-stage load/store unit that consumes execute-stage results and drives the data-memory bus. It uses a req/gnt/rvalid handshake toward memory. For loads, it aligns and sign- or zero-extends the read data. It stalls the pipeline while an access is outstanding and registers the writeback bundle toward the WB stage. Non-memory instructions pass through with 1-cycle latency.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_mem_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared LSU definitions: access sizes, FSM states, exception bit positions,
// and the misalignment rule used by the memory stage.
package riscv_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam int EXC_LD_MISALIGN = 0;
  localparam int EXC_ST_MISALIGN = 1;
  localparam int EXC_BUS_ERR     = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } lsu_state_t;

  // Load context captured at grant time and consumed when rvalid returns.
  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] size;
    logic       is_unsigned;
  } ld_ctx_t;

  // Size 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_SIZE_HALF) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    result = rdata;
    case (size)
      MEM_SIZE_BYTE: result = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      MEM_SIZE_HALF: result = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: req/gnt/rvalid data bus, load alignment, stall control
// and a registered writeback bundle. Define LSU_BUS_TIMEOUT_EN to abandon
// accesses that wait TIMEOUT_CYCLES and flag a bus error.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int REG_NUM        = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [ADDRESS_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]      i_store_data,
  input  logic                       i_is_load,
  input  logic                       i_is_store,
  input  logic [1:0]                 i_mem_size,
  input  logic                       i_mem_load_unsigned,
  input  logic                       i_rf_wr_en,
  input  logic [$clog2(REG_NUM)-1:0] i_rd_addr,
  input  logic [ADDRESS_WIDTH-1:0]   i_pc,
  output logic                       o_stall,
  output logic                       o_dmem_req,
  output logic                       o_dmem_we,
  output logic [ADDRESS_WIDTH-1:0]   o_dmem_addr,
  output logic [3:0]                 o_dmem_be,
  output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                       i_dmem_gnt,
  input  logic                       i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
  output logic                       o_wb_valid,
  output logic                       o_wb_rf_wr_en,
  output logic [$clog2(REG_NUM)-1:0] o_wb_rd_addr,
  output logic [DATA_WIDTH-1:0]      o_wb_data,
  output logic [ADDRESS_WIDTH-1:0]   o_wb_pc,
  output logic [2:0]                 o_m_exception
);

  lsu_state_t state, state_nxt;
  ld_ctx_t    ctx;

  logic                  mem_op, misalign, req_raw, req, timeout;
  logic                  fire, ld_done;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata, ld_val;
  logic [2:0]            exc_nxt;

  assign mem_op   = i_valid & (i_is_load | i_is_store);
  assign misalign = mem_op & is_misaligned(i_mem_size, i_addr[1:0]);
  assign req_raw  = (state == IDLE) & mem_op & ~misalign;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          waiting;

  assign waiting = (state == IDLE) ? (req_raw & ~i_dmem_gnt) : ~i_dmem_rvalid;
  assign timeout = waiting & (to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   to_cnt <= '0;
    else if (!waiting || timeout) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    be    = 4'hF;
    wdata = i_store_data;
    case (i_mem_size)
      MEM_SIZE_BYTE: begin
        be    = 4'b0001 << i_addr[1:0];
        wdata = {4{i_store_data[7:0]}};
      end
      MEM_SIZE_HALF: begin
        be    = 4'b0011 << i_addr[1:0];
        wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign o_dmem_req   = req;
  assign o_dmem_we    = req & i_is_store & ~i_is_load;
  assign o_dmem_addr  = req ? {i_addr[ADDRESS_WIDTH-1:2], 2'b00} : '0;
  assign o_dmem_be    = req ? be : 4'h0;
  assign o_dmem_wdata = req ? wdata : '0;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    o_stall   = 1'b0;
    fire      = 1'b0;
    ld_done   = 1'b0;
    unique case (state)
      IDLE: begin
        req = req_raw & ~timeout;
        if (timeout) begin
          fire = 1'b1;
        end else if (req_raw) begin
          if (!i_dmem_gnt)     o_stall = 1'b1;
          else if (i_is_load) begin
            o_stall   = 1'b1;
            state_nxt = WAIT_RSP;
          end else             fire = 1'b1;
        end else begin
          fire = i_valid;
        end
      end
      WAIT_RSP: begin
        if (timeout) begin
          fire      = 1'b1;
          state_nxt = IDLE;
        end else if (i_dmem_rvalid) begin
          fire      = 1'b1;
          ld_done   = 1'b1;
          state_nxt = IDLE;
        end else begin
          o_stall = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    exc_nxt                  = '0;
    exc_nxt[EXC_LD_MISALIGN] = misalign & i_is_load;
    exc_nxt[EXC_ST_MISALIGN] = misalign & ~i_is_load;
    exc_nxt[EXC_BUS_ERR]     = timeout;
  end

  lsu_load_align u_align (
    .rdata      (i_dmem_rdata),
    .offset     (ctx.offset),
    .size       (ctx.size),
    .is_unsigned(ctx.is_unsigned),
    .result     (ld_val)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      ctx   <= '0;
    end else begin
      state <= state_nxt;
      if (req & i_dmem_gnt & i_is_load)
        ctx <= '{offset: i_addr[1:0], size: i_mem_size, is_unsigned: i_mem_load_unsigned};
    end
  end

  // The bundle is cleared on non-firing cycles so a bubble never carries stale state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_valid    <= 1'b0;
      o_wb_rf_wr_en <= 1'b0;
      o_wb_rd_addr  <= '0;
      o_wb_data     <= '0;
      o_wb_pc       <= '0;
      o_m_exception <= '0;
    end else if (fire) begin
      o_wb_valid    <= 1'b1;
      o_wb_rf_wr_en <= i_rf_wr_en & (ld_done | ~(i_is_load | i_is_store));
      o_wb_rd_addr  <= i_rd_addr;
      o_wb_data     <= ld_done ? ld_val : DATA_WIDTH'(i_addr);
      o_wb_pc       <= i_pc;
      o_m_exception <= exc_nxt;
    end else begin
      o_wb_valid    <= 1'b0;
      o_wb_rf_wr_en <= 1'b0;
      o_wb_rd_addr  <= '0;
      o_wb_data     <= '0;
      o_wb_pc       <= '0;
      o_m_exception <= '0;
    end
  end

endmodule
